// File: rtl/logic_op_pipe.sv
// rtl/logic_op_pipe.sv - multi-operand masked bitwise logic unit with elastic valid/ready pipeline
//
// Combines NUM_IN operands of WIDTH bits under a runtime opcode, with per-operand masking,
// and carries the result through STAGES elastic register stages.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous reset, active-high
//   valid_i    input transaction valid
//   ready_o    block can accept input this cycle
//   op_i       0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved
//   mask_i     operand enable, bit k gates operand k
//   data_i     operands, operand k = data_i[k*WIDTH +: WIDTH]
//   valid_o    result valid
//   ready_i    downstream accepts result
//   y_o        bitwise result
//   red_and_o  &y_o
//   red_or_o   |y_o
//   err_o      result came from a reserved opcode
//   txn_cnt_o  count of output handshakes, wraps at 16 bits

module logic_op_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [2:0]                op_i,
  input  logic [NUM_IN-1:0]         mask_i,
  input  logic [NUM_IN*WIDTH-1:0]   data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [WIDTH-1:0]          y_o,
  output logic                      red_and_o,
  output logic                      red_or_o,
  output logic                      err_o,
  output logic [15:0]               txn_cnt_o
);

  // Stage payload: {err, red_and, red_or, y}
  localparam int PW = WIDTH + 3;

  logic [WIDTH-1:0]  and_all;
  logic [WIDTH-1:0]  or_all;
  logic [WIDTH-1:0]  xor_all;
  logic [WIDTH-1:0]  y_d;
  logic              err_d;
  logic [PW-1:0]     res_d;
  logic [STAGES-1:0] stg_v;
  logic [STAGES-1:0] stg_ld;
  logic [PW-1:0]     stg_q [STAGES];
  logic [15:0]       txn_cnt_q;

  // Masked-off operands become the identity of their op class, so a disabled operand
  // never influences the reduction. The chain lives in per-iteration signals to keep
  // each accumulator a distinct net.
  for (genvar k = 0; k < NUM_IN; k++) begin : g_opnd
    logic [WIDTH-1:0] one_in;
    logic [WIDTH-1:0] zero_in;
    logic [WIDTH-1:0] and_acc;
    logic [WIDTH-1:0] or_acc;
    logic [WIDTH-1:0] xor_acc;

    assign one_in  = mask_i[k] ? data_i[k*WIDTH +: WIDTH] : {WIDTH{1'b1}};
    assign zero_in = mask_i[k] ? data_i[k*WIDTH +: WIDTH] : {WIDTH{1'b0}};

    if (k == 0) begin : g_first
      assign and_acc = one_in;
      assign or_acc  = zero_in;
      assign xor_acc = zero_in;
    end else begin : g_next
      assign and_acc = g_opnd[k-1].and_acc & one_in;
      assign or_acc  = g_opnd[k-1].or_acc  | zero_in;
      assign xor_acc = g_opnd[k-1].xor_acc ^ zero_in;
    end
  end

  assign and_all = g_opnd[NUM_IN-1].and_acc;
  assign or_all  = g_opnd[NUM_IN-1].or_acc;
  assign xor_all = g_opnd[NUM_IN-1].xor_acc;

  // Inverting ops invert the full reduction, not a pairwise chain.
  always_comb begin
    y_d   = '0;
    err_d = 1'b0;
    case (op_i)
      3'd0:    y_d = and_all;
      3'd1:    y_d = or_all;
      3'd2:    y_d = xor_all;
      3'd3:    y_d = ~and_all;
      3'd4:    y_d = ~or_all;
      3'd5:    y_d = ~xor_all;
      default: err_d = 1'b1;
    endcase
  end

  assign res_d = {err_d, &y_d, |y_d, y_d};

  // A stage loads when it or any stage after it is empty, or the sink is taking data.
  // This is the recursive "empty or next loading" rule flattened, so ready_o is a
  // single combinational path from ready_i and the valid bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_ld
    assign stg_ld[k] = ready_i || !(&stg_v[STAGES-1:k]);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          v_in;
    logic [PW-1:0] d_in;
    logic          v_q;
    logic [PW-1:0] q_q;

    if (k == 0) begin : g_head
      assign v_in = valid_i;
      assign d_in = res_d;
    end else begin : g_body
      assign v_in = stg_v[k-1];
      assign d_in = stg_q[k-1];
    end

    // Payload only updates on a real transaction, so bubbles do not disturb held data.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        v_q <= 1'b0;
        q_q <= '0;
      end else if (stg_ld[k]) begin
        v_q <= v_in;
        if (v_in) begin
          q_q <= d_in;
        end
      end
    end

    assign stg_v[k] = v_q;
    assign stg_q[k] = q_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      txn_cnt_q <= 16'd0;
    end else if (valid_o && ready_i) begin
      txn_cnt_q <= txn_cnt_q + 16'd1;
    end
  end

  assign ready_o   = stg_ld[0];
  assign valid_o   = stg_v[STAGES-1];
  assign err_o     = stg_q[STAGES-1][PW-1];
  assign red_and_o = stg_q[STAGES-1][PW-2];
  assign red_or_o  = stg_q[STAGES-1][PW-3];
  assign y_o       = stg_q[STAGES-1][WIDTH-1:0];
  assign txn_cnt_o = txn_cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb/tb_logic_op_pipe.sv - scoreboard bench for logic_op_pipe (WIDTH=8, NUM_IN=4, STAGES=2)

module tb_logic_op_pipe;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [7:0]  y;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic       err;
    logic [7:0] y;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [2:0]  op_i = 3'd0;
  logic [3:0]  mask_i = 4'd0;
  logic [31:0] data_i = 32'd0;
  logic        ready_o;
  logic        valid_o;
  logic [7:0]  y_o;
  logic        red_and_o;
  logic        red_or_o;
  logic        err_o;
  logic [15:0] txn_cnt_o;

  vec_t  vecs [12];
  exp_t  sb [$];
  exp_t  e;
  int    xfer_cyc [$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    n_acc = 0;
  int    n_stall = 0;
  int    cyc = 0;
  logic        prev_stall = 1'b0;
  logic [11:0] prev_out = '0;

  logic_op_pipe #(.WIDTH(8), .NUM_IN(4), .STAGES(2)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .op_i      (op_i),
    .mask_i    (mask_i),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .y_o       (y_o),
    .red_and_o (red_and_o),
    .red_or_o  (red_or_o),
    .err_o     (err_o),
    .txn_cnt_o (txn_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, after inputs settle and before the next rising edge.
  always begin
    @(negedge clk);
    #3;
    cyc++;
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold", {20'd0, valid_o, err_o, red_and_o, red_or_o, y_o}, {20'd0, prev_out});
      end
      if (valid_o && ready_i) begin
        xfer_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got y=%h err=%b, scoreboard empty", y_o, err_o);
        end else begin
          e = sb.pop_front();
          chk("y", {24'd0, y_o}, {24'd0, e.y});
          chk("err", {31'd0, err_o}, {31'd0, e.err});
          chk("red_and", {31'd0, red_and_o}, {31'd0, &e.y});
          chk("red_or", {31'd0, red_or_o}, {31'd0, |e.y});
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_out   = {valid_o, err_o, red_and_o, red_or_o, y_o};
    end
  end

  task automatic send(input vec_t v);
    int w;
    w = 0;
    @(negedge clk);
    #1;
    valid_i = 1'b1;
    op_i    = v.op;
    mask_i  = v.mask;
    data_i  = v.data;
    #1;
    while (!ready_o && w < 100) begin
      @(negedge clk);
      #2;
      w++;
    end
    if (!ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: ready_o=%b after %0d cycles", ready_o, w);
    end else begin
      sb.push_back('{err: v.err, y: v.y});
      n_acc++;
      n_stall += w;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || valid_o) && w < 50) begin
      @(negedge clk);
      #4;
      w++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{op: 3'd0, mask: 4'hF, data: 32'hFFF03CFF, y: 8'h30, err: 1'b0};
    vecs[1]  = '{op: 3'd3, mask: 4'h2, data: 32'h0000A500, y: 8'h5A, err: 1'b0};
    vecs[2]  = '{op: 3'd3, mask: 4'h0, data: 32'hA5A5A5A5, y: 8'h00, err: 1'b0};
    vecs[3]  = '{op: 3'd0, mask: 4'h0, data: 32'h12345678, y: 8'hFF, err: 1'b0};
    vecs[4]  = '{op: 3'd6, mask: 4'hF, data: 32'hFFFFFFFF, y: 8'h00, err: 1'b1};
    vecs[5]  = '{op: 3'd1, mask: 4'hF, data: 32'h01020408, y: 8'h0F, err: 1'b0};
    vecs[6]  = '{op: 3'd2, mask: 4'hF, data: 32'hFF0F3355, y: 8'h96, err: 1'b0};
    vecs[7]  = '{op: 3'd5, mask: 4'hF, data: 32'hFF0F3355, y: 8'h69, err: 1'b0};
    vecs[8]  = '{op: 3'd4, mask: 4'h5, data: 32'h00100002, y: 8'hED, err: 1'b0};
    vecs[9]  = '{op: 3'd1, mask: 4'hA, data: 32'h80000100, y: 8'h81, err: 1'b0};
    vecs[10] = '{op: 3'd7, mask: 4'h3, data: 32'hFFFFFFFF, y: 8'h00, err: 1'b1};
    vecs[11] = '{op: 3'd0, mask: 4'h3, data: 32'h0000F00F, y: 8'h00, err: 1'b0};

    repeat (2) @(negedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
    chk("rst_y_o", {24'd0, y_o}, 32'd0);
    chk("rst_err_o", {31'd0, err_o}, 32'd0);
    chk("rst_red_and", {31'd0, red_and_o}, 32'd0);
    chk("rst_red_or", {31'd0, red_or_o}, 32'd0);
    chk("rst_cnt", {16'd0, txn_cnt_o}, 32'd0);

    // Latency: accepted at edge n, valid_o visible in cycle n+2.
    send(vecs[0]);
    @(negedge clk);
    #1;
    valid_i = 1'b0;
    #2;
    chk("lat_cycle1", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    #3;
    chk("lat_cycle2", {31'd0, valid_o}, 32'd1);
    drain();
    chk("cnt_after_1", {16'd0, txn_cnt_o}, 32'd1);

    // Back-to-back burst of 8 with ready_i held high.
    xfer_cyc.delete();
    n_stall = 0;
    for (int i = 1; i <= 8; i++) send(vecs[i]);
    idle();
    drain();
    chk("burst_stalls", n_stall, 32'd0);
    chk("burst_xfers", xfer_cyc.size(), 32'd8);
    if (xfer_cyc.size() == 8) chk("burst_span", xfer_cyc[7] - xfer_cyc[0], 32'd7);
    chk("cnt_after_9", {16'd0, txn_cnt_o}, 32'd9);

    for (int i = 9; i <= 11; i++) send(vecs[i]);
    idle();
    drain();
    chk("cnt_after_12", {16'd0, txn_cnt_o}, 32'd12);

    // Downstream stall: two accepts fill the pipe, then ready_o drops.
    @(negedge clk);
    #1;
    ready_i = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(vecs[i]);
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        #2;
        chk("stall_accepts", n_acc, 32'd2);
        chk("stall_ready_o", {31'd0, ready_o}, 32'd0);
        chk("stall_valid_o", {31'd0, valid_o}, 32'd1);
        chk("stall_cnt", {16'd0, txn_cnt_o}, 32'd12);
        @(negedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();
    chk("cnt_after_17", {16'd0, txn_cnt_o}, 32'd17);

    // Reset while full and stalled.
    @(negedge clk);
    #1;
    ready_i = 1'b0;
    valid_i = 1'b1;
    op_i    = 3'd0;
    mask_i  = 4'hF;
    data_i  = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    valid_i = 1'b0;
    #2;
    chk("full_valid_o", {31'd0, valid_o}, 32'd1);
    chk("full_ready_o", {31'd0, ready_o}, 32'd0);
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("midrst_cnt", {16'd0, txn_cnt_o}, 32'd0);
    chk("midrst_y_o", {24'd0, y_o}, 32'd0);
    chk("midrst_red_and", {31'd0, red_and_o}, 32'd0);
    chk("midrst_err_o", {31'd0, err_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_i   = 1'b0;
    ready_i = 1'b1;
    #1;
    chk("post_rst_ready_o", {31'd0, ready_o}, 32'd1);

    // Counter wrap.
    for (int i = 0; i < 65535; i++) send(vecs[5]);
    idle();
    drain();
    chk("cnt_ffff", {16'd0, txn_cnt_o}, 32'h0000FFFF);
    send(vecs[3]);
    idle();
    drain();
    chk("cnt_wrap", {16'd0, txn_cnt_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
